// File: rtl/timer0_peripheral_pkg.sv
// Shared TMR0/OPTION_REG register map, OPTION_REG bit positions and decode helpers.
// latency: n/a (constants and pure functions only)
// backpressure: n/a
package timer0_peripheral_pkg;

    localparam logic [8:0] TMR0_ADDR_B0   = 9'h001;
    localparam logic [8:0] TMR0_ADDR_B1   = 9'h101;
    localparam logic [8:0] OPTION_ADDR_B0 = 9'h081;
    localparam logic [8:0] OPTION_ADDR_B1 = 9'h181;

    localparam int OPT_NRBPU  = 7;
    localparam int OPT_INTEDG = 6;
    localparam int OPT_T0CS   = 5;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_PSA    = 3;
    localparam int OPT_PS_MSB = 2;
    localparam int OPT_PS_LSB = 0;

    localparam logic [7:0] OPTION_RST   = 8'hFF;
    localparam logic [1:0] INHIBIT_LOAD = 2'd2;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_TMR0,
        REG_OPTION
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [8:0] a);
        case (a)
            TMR0_ADDR_B0, TMR0_ADDR_B1:     return REG_TMR0;
            OPTION_ADDR_B0, OPTION_ADDR_B1: return REG_OPTION;
            default:                        return REG_NONE;
        endcase
    endfunction

    // Terminal prescaler count 2^(ps+1)-1: ps=0 -> 1 (div 2), ps=7 -> 255 (div 256).
    function automatic logic [7:0] ps_terminal(input logic [2:0] ps);
        return 8'hFF >> (3'd7 - ps);
    endfunction

endpackage

// File: rtl/timer0_peripheral_if.sv
// Core-side register-file bus for the timer0 peripheral.
// latency: reads combinational, writes land on the wr_en edge
// backpressure: none, the peripheral accepts every access
interface timer0_peripheral_if;
    logic [8:0] addr;
    logic [7:0] data_in;
    logic       wr_en;
    logic [7:0] data_out;
    logic       sel;

    modport master (output addr, output data_in, output wr_en, input data_out, input sel);
    modport slave  (input addr, input data_in, input wr_en, output data_out, output sel);
endinterface

// File: rtl/t0cki_edge_sync.sv
// Synchronizes the T0CKI pin and detects the selected edge.
// latency: transition sampled at edge k raises evt after edge k+1, for one clk
// backpressure: none; pulses shorter than 2 clk may be lost
module t0cki_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic t0cki,
    input  logic edge_sel,
    output logic evt
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= t0cki;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // edge_sel=0 counts rising edges, edge_sel=1 falling edges
    assign evt = edge_sel ? (~s2 & s3) : (s2 & ~s3);
endmodule

// File: rtl/timer0_peripheral.sv
// TMR0 + OPTION_REG with 8-bit prescaler and internal/T0CKI source.
// latency: reads combinational; internal increment at inst_tick edge, T0CKI 3 clk
// backpressure: none; register writes always accepted, events never stalled
module timer0_peripheral
    import timer0_peripheral_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    timer0_peripheral_if.slave   bus,
    input  logic                 inst_tick,
    input  logic                 t0cki,
    output logic                 t0if_set,
    output logic [7:0]           option_out
);
    logic [7:0] tmr0;
    logic [7:0] option_reg;
    logic [7:0] presc;
    logic [7:0] presc_nxt;
    logic [1:0] inhibit;
    logic       ext_evt;
    logic       evt;
    logic       tmr0_inc;
    logic       inhibited;
    logic       wr_tmr0;
    logic       wr_opt;
    reg_sel_e   hit;

    assign hit       = decode_addr(bus.addr);
    assign wr_tmr0   = bus.wr_en && (hit == REG_TMR0);
    assign wr_opt    = bus.wr_en && (hit == REG_OPTION);
    assign inhibited = (inhibit != 2'd0);
    assign option_out = option_reg;

    t0cki_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .t0cki    (t0cki),
        .edge_sel (option_reg[OPT_T0SE]),
        .evt      (ext_evt)
    );

    assign evt = option_reg[OPT_T0CS] ? ext_evt : inst_tick;

    always_comb begin
        bus.data_out = 8'h00;
        bus.sel      = 1'b0;
        case (hit)
            REG_TMR0: begin
                bus.data_out = tmr0;
                bus.sel      = 1'b1;
            end
            REG_OPTION: begin
                bus.data_out = option_reg;
                bus.sel      = 1'b1;
            end
            default: ;
        endcase
    end

    // Events are qualified by the OPTION_REG value from before any same-cycle write.
    always_comb begin
        tmr0_inc  = 1'b0;
        presc_nxt = presc;
        if (inhibited || option_reg[OPT_PSA]) begin
            presc_nxt = 8'h00;
            tmr0_inc  = evt && !inhibited;
        end else if (evt) begin
            if (presc == ps_terminal(option_reg[OPT_PS_MSB:OPT_PS_LSB])) begin
                presc_nxt = 8'h00;
                tmr0_inc  = 1'b1;
            end else begin
                presc_nxt = presc + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr0       <= 8'h00;
            option_reg <= OPTION_RST;
            presc      <= 8'h00;
            inhibit    <= 2'd0;
            t0if_set   <= 1'b0;
        end else begin
            t0if_set <= 1'b0;
            if (inst_tick && inhibited)
                inhibit <= inhibit - 2'd1;
            if (wr_tmr0) begin
                tmr0    <= bus.data_in;
                presc   <= 8'h00;
                inhibit <= INHIBIT_LOAD;
            end else begin
                if (tmr0_inc) begin
                    tmr0     <= tmr0 + 8'd1;
                    t0if_set <= (tmr0 == 8'hFF);
                end
                presc <= presc_nxt;
                if (wr_opt) begin
                    option_reg <= bus.data_in;
                    if (bus.data_in[OPT_PSA] != option_reg[OPT_PSA])
                        presc <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_timer0_peripheral.sv
// Directed bench for timer0_peripheral with a scoreboard-driven read monitor.
// latency: n/a
// backpressure: n/a
module tb_timer0_peripheral;

    typedef struct {
        string      name;
        logic [7:0] d;
        logic       s;
        logic       t;
        logic [7:0] o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       inst_tick;
    logic       t0cki;
    logic       t0if_set;
    logic [7:0] option_out;

    logic       chk_vld = 1'b0;
    logic       done = 1'b0;
    logic       drained = 1'b0;
    logic [7:0] cur_opt = 8'hFF;
    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];

    timer0_peripheral_if bus ();

    timer0_peripheral dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .inst_tick  (inst_tick),
        .t0cki      (t0cki),
        .t0if_set   (t0if_set),
        .option_out (option_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (chk_vld) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow: got read with no expectation, required queued entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.data_out !== e.d || bus.sel !== e.s || t0if_set !== e.t || option_out !== e.o) begin
                    fails++;
                    $display("FAIL %s: got data=%02h sel=%0b t0if=%0b opt=%02h, required data=%02h sel=%0b t0if=%0b opt=%02h",
                             e.name, bus.data_out, bus.sel, t0if_set, option_out, e.d, e.s, e.t, e.o);
                end
            end
        end
        if (done && !drained) begin
            drained = 1'b1;
            tests++;
            if (sb.size() != 0) begin
                fails++;
                $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.data_in = d;
        bus.wr_en   = 1'b1;
        if (a == 9'h081 || a == 9'h181)
            cur_opt = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            inst_tick = 1'b1;
            step();
            inst_tick = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [8:0] a, input logic [7:0] d,
                       input logic s, input logic t);
        bus.addr = a;
        sb.push_back('{name, d, s, t, cur_opt});
        chk_vld = 1'b1;
        step();
        chk_vld = 1'b0;
    endtask

    task automatic chk_t(input string name, input logic [7:0] d, input logic t);
        chk(name, 9'h001, d, 1'b1, t);
    endtask

    initial begin
        rst         = 1'b0;
        inst_tick   = 1'b0;
        t0cki       = 1'b0;
        bus.addr    = 9'h000;
        bus.data_in = 8'h00;
        bus.wr_en   = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // count a little, then reset mid-count
        wr(9'h081, 8'h08);
        ticks(3);
        chk_t("pre_reset_count", 8'h03, 1'b0);
        rst = 1'b0;
        cur_opt = 8'hFF;
        chk("in_reset_option", 9'h081, 8'hFF, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk("reset_option", 9'h081, 8'hFF, 1'b1, 1'b0);
        chk_t("reset_tmr0", 8'h00, 1'b0);
        chk("miss_005", 9'h005, 8'h00, 1'b0, 1'b0);
        chk("mirror_181", 9'h181, 8'hFF, 1'b1, 1'b0);

        // post-reset falling-edge mode: high level is not an event, the fall is
        t0cki = 1'b1;
        step();
        for (int i = 0; i < 4; i++) chk_t("rst_ext_high", 8'h00, 1'b0);
        t0cki = 1'b0;
        step();
        chk_t("rst_ext_fall_k1", 8'h00, 1'b0);
        chk_t("rst_ext_fall_k2", 8'h00, 1'b0);
        chk_t("rst_ext_fall_inc", 8'h01, 1'b0);

        // internal count, inhibit window, overflow
        wr(9'h081, 8'h08);
        chk("opt_08", 9'h081, 8'h08, 1'b1, 1'b0);
        wr(9'h001, 8'hFD);
        ticks(2);
        chk_t("inhibit_hold", 8'hFD, 1'b0);
        ticks(1);
        chk_t("inc_fe", 8'hFE, 1'b0);
        ticks(1);
        chk("inc_ff_mirror", 9'h101, 8'hFF, 1'b1, 1'b0);
        ticks(1);
        chk_t("wrap_00_t0if", 8'h00, 1'b1);
        chk_t("t0if_one_clk", 8'h00, 1'b0);

        // prescaler divide by 8
        wr(9'h081, 8'h02);
        wr(9'h001, 8'h00);
        ticks(2);
        ticks(7);
        chk_t("presc_7", 8'h00, 1'b0);
        ticks(1);
        chk_t("presc_8", 8'h01, 1'b0);
        ticks(8);
        chk_t("presc_16", 8'h02, 1'b0);
        ticks(3);
        wr(9'h001, 8'h10);
        ticks(2);
        ticks(7);
        chk_t("presc_restart_7", 8'h10, 1'b0);
        ticks(1);
        chk_t("presc_restart_8", 8'h11, 1'b0);

        // PSA toggle clears a partial prescale of 5
        wr(9'h001, 8'h20);
        ticks(2);
        ticks(5);
        wr(9'h081, 8'h0A);
        wr(9'h081, 8'h02);
        ticks(7);
        chk_t("psa_toggle_7", 8'h20, 1'b0);
        ticks(1);
        chk_t("psa_toggle_8", 8'h21, 1'b0);

        // write collides with an increment from 0xFF
        wr(9'h181, 8'h08);
        wr(9'h101, 8'hFF);
        ticks(2);
        chk_t("sim_pre", 8'hFF, 1'b0);
        inst_tick = 1'b1;
        wr(9'h001, 8'h40);
        inst_tick = 1'b0;
        chk_t("sim_write_wins", 8'h40, 1'b0);

        // external rising edges
        wr(9'h081, 8'h28);
        wr(9'h001, 8'h50);
        ticks(2);
        chk_t("ext_start", 8'h50, 1'b0);
        t0cki = 1'b1;
        step();
        chk_t("ext_rise_k", 8'h50, 1'b0);
        chk_t("ext_rise_k1", 8'h50, 1'b0);
        chk_t("ext_rise_inc", 8'h51, 1'b0);
        t0cki = 1'b0;
        step();
        for (int i = 0; i < 4; i++) chk_t("ext_fall_ignored", 8'h51, 1'b0);
        t0cki = 1'b1;
        step();
        chk_t("ext_rise2_k", 8'h51, 1'b0);
        chk_t("ext_rise2_k1", 8'h51, 1'b0);
        chk_t("ext_rise2_inc", 8'h52, 1'b0);

        // external falling edges
        wr(9'h081, 8'h38);
        t0cki = 1'b0;
        step();
        chk_t("ext_t0se_k", 8'h52, 1'b0);
        chk_t("ext_t0se_k1", 8'h52, 1'b0);
        chk_t("ext_t0se_inc", 8'h53, 1'b0);
        t0cki = 1'b1;
        step();
        for (int i = 0; i < 4; i++) chk_t("ext_t0se_rise_ignored", 8'h53, 1'b0);

        done = 1'b1;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
